// File: rtl/pipe_stage_buf.sv
// Two-entry pipeline stage buffer (main + skid) with registered ready, flush and a
// saturating count of entries discarded by flush. All state updates on the falling clock edge.
module pipe_stage_buf #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [WIDTH-1:0]  In_Data,
  input  logic [CTRL_W-1:0] In_Ctrl,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [WIDTH-1:0]  Out_Data,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [1:0]        Occupancy,
  output logic [CNT_W-1:0]  Drop_Cnt
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  localparam int unsigned SumW = CNT_W + 2;

  state_e              r_state, w_state_next;
  logic [WIDTH-1:0]    r_main_data, w_main_data_next;
  logic [CTRL_W-1:0]   r_main_ctrl, w_main_ctrl_next;
  logic [WIDTH-1:0]    r_skid_data, w_skid_data_next;
  logic [CTRL_W-1:0]   r_skid_ctrl, w_skid_ctrl_next;
  logic [CNT_W-1:0]    r_drop_cnt, w_drop_cnt_next;
  logic [SumW-1:0]     w_drop_sum;
  logic [CNT_W-1:0]    w_drop_sat;
  logic                w_accept;
  logic                w_pop;

  assign Occupancy = r_state;
  assign In_Ready  = (r_state != StFull);
  assign Out_Valid = (r_state != StEmpty);
  assign Out_Data  = (r_state == StEmpty) ? '0 : r_main_data;
  assign Out_Ctrl  = (r_state == StEmpty) ? '0 : r_main_ctrl;
  assign Drop_Cnt  = r_drop_cnt;

  assign w_accept = In_Valid && In_Ready;
  assign w_pop    = Out_Valid && Out_Ready;

  assign w_drop_sum = {{CNT_W{1'b0}}, Occupancy} + {2'b00, r_drop_cnt};
  assign w_drop_sat = (|w_drop_sum[SumW-1:CNT_W]) ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];

  always_comb begin
    w_state_next     = r_state;
    w_main_data_next = r_main_data;
    w_main_ctrl_next = r_main_ctrl;
    w_skid_data_next = r_skid_data;
    w_skid_ctrl_next = r_skid_ctrl;
    w_drop_cnt_next  = r_drop_cnt;
    if (Flush) begin
      // Flush wins over accept and pop; an entry offered on this edge is dropped silently.
      w_state_next     = StEmpty;
      w_main_data_next = '0;
      w_main_ctrl_next = '0;
      w_skid_data_next = '0;
      w_skid_ctrl_next = '0;
      w_drop_cnt_next  = w_drop_sat;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (w_accept) begin
            w_main_data_next = In_Data;
            w_main_ctrl_next = In_Ctrl;
            w_state_next     = StOne;
          end
        end
        StOne: begin
          if (w_accept && !w_pop) begin
            w_skid_data_next = In_Data;
            w_skid_ctrl_next = In_Ctrl;
            w_state_next     = StFull;
          end else if (!w_accept && w_pop) begin
            w_state_next = StEmpty;
          end else if (w_accept && w_pop) begin
            w_main_data_next = In_Data;
            w_main_ctrl_next = In_Ctrl;
          end
        end
        StFull: begin
          if (w_pop) begin
            w_main_data_next = r_skid_data;
            w_main_ctrl_next = r_skid_ctrl;
            w_state_next     = StOne;
          end
        end
        default: w_state_next = StEmpty;
      endcase
    end
  end

  always_ff @(negedge Clk) begin
    if (Clr) begin
      r_state     <= StEmpty;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_main_data <= w_main_data_next;
      r_main_ctrl <= w_main_ctrl_next;
      r_skid_data <= w_skid_data_next;
      r_skid_ctrl <= w_skid_ctrl_next;
      r_drop_cnt  <= w_drop_cnt_next;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: default-width instance for datapath scenarios and a
// CNT_W=2 instance for drop-counter saturation.
module tb_pipe_stage_buf;

  logic        clk;
  logic        a_clr, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [7:0]  a_in_ctrl, a_out_ctrl, a_drop;
  logic [1:0]  a_occ;

  logic        b_clr, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_in_data, b_out_data;
  logic [3:0]  b_in_ctrl, b_out_ctrl;
  logic [1:0]  b_occ, b_drop;

  int checks = 0;
  int errors = 0;

  pipe_stage_buf u_dut_a (
    .Clk      (clk),
    .Clr      (a_clr),
    .Flush    (a_flush),
    .In_Valid (a_in_valid),
    .In_Ready (a_in_ready),
    .In_Data  (a_in_data),
    .In_Ctrl  (a_in_ctrl),
    .Out_Valid(a_out_valid),
    .Out_Ready(a_out_ready),
    .Out_Data (a_out_data),
    .Out_Ctrl (a_out_ctrl),
    .Occupancy(a_occ),
    .Drop_Cnt (a_drop)
  );

  pipe_stage_buf #(.WIDTH(8), .CTRL_W(4), .CNT_W(2)) u_dut_b (
    .Clk      (clk),
    .Clr      (b_clr),
    .Flush    (b_flush),
    .In_Valid (b_in_valid),
    .In_Ready (b_in_ready),
    .In_Data  (b_in_data),
    .In_Ctrl  (b_in_ctrl),
    .Out_Valid(b_out_valid),
    .Out_Ready(b_out_ready),
    .Out_Data (b_out_data),
    .Out_Ctrl (b_out_ctrl),
    .Occupancy(b_occ),
    .Drop_Cnt (b_drop)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Advance past the next falling (active) edge; outputs are then stable for sampling.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic [31:0] d, input logic r);
    a_in_valid  = v;
    a_in_data   = d;
    a_in_ctrl   = d[7:0] ^ 8'hA5;
    a_out_ready = r;
  endtask

  task automatic test_reset();
    a_clr = 1'b1;
    a_drive(1'b1, 32'h77, 1'b0);
    tick();
    checks++;
    if (a_occ !== 2'd0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state occ=%0d ov=%b ir=%b want 0/0/1", a_occ, a_out_valid, a_in_ready);
    end
    checks++;
    if (a_out_data !== 32'h0 || a_out_ctrl !== 8'h0 || a_drop !== 8'h0) begin
      errors++;
      $display("FAIL reset_zero data=%0h ctrl=%0h drop=%0d want 0", a_out_data, a_out_ctrl, a_drop);
    end
    a_clr = 1'b0;
  endtask

  task automatic test_single();
    a_drive(1'b1, 32'h11, 1'b1);
    tick();
    checks++;
    if (a_out_valid !== 1'b1 || a_out_data !== 32'h11 || a_out_ctrl !== 8'hB4) begin
      errors++;
      $display("FAIL single_out ov=%b data=%0h ctrl=%0h want 1/11/b4",
               a_out_valid, a_out_data, a_out_ctrl);
    end
    a_drive(1'b0, 32'h0, 1'b1);
    tick();
    checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== 32'h0 || a_occ !== 2'd0) begin
      errors++;
      $display("FAIL single_drain ov=%b data=%0h occ=%0d want 0/0/0", a_out_valid, a_out_data, a_occ);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'hB;
    exp_seq[1] = 32'hC;
    exp_seq[2] = 32'h0;
    a_drive(1'b1, 32'hA, 1'b0);
    tick();
    checks++;
    if (a_occ !== 2'd1 || a_out_data !== 32'hA) begin
      errors++;
      $display("FAIL bp_one occ=%0d data=%0h want 1/a", a_occ, a_out_data);
    end
    a_drive(1'b1, 32'hB, 1'b0);
    tick();
    checks++;
    if (a_occ !== 2'd2 || a_in_ready !== 1'b0 || a_out_data !== 32'hA) begin
      errors++;
      $display("FAIL bp_full occ=%0d ir=%b data=%0h want 2/0/a", a_occ, a_in_ready, a_out_data);
    end
    a_drive(1'b1, 32'hC, 1'b0);
    tick();
    checks++;
    if (a_occ !== 2'd2 || a_out_data !== 32'hA) begin
      errors++;
      $display("FAIL bp_holdoff occ=%0d data=%0h want 2/a", a_occ, a_out_data);
    end
    // A was at the head before release; B, C follow, then empty.
    for (int i = 0; i < 3; i++) begin
      a_drive(i < 2, 32'hC, 1'b1);
      tick();
      checks++;
      if (a_out_data !== exp_seq[i] || a_out_valid !== (i < 2)) begin
        errors++;
        $display("FAIL bp_order[%0d] data=%0h ov=%b want %0h/%b",
                 i, a_out_data, a_out_valid, exp_seq[i], (i < 2));
      end
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 10; i++) begin
      a_drive(1'b1, i, 1'b1);
      tick();
      checks++;
      if (a_occ !== 2'd1 || a_out_data !== i || a_out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream[%0d] occ=%0d data=%0h ov=%b want 1/%0h/1",
                 i, a_occ, a_out_data, a_out_valid, i);
      end
    end
    a_drive(1'b0, 32'h0, 1'b1);
    tick();
    checks++;
    if (a_occ !== 2'd0) begin
      errors++;
      $display("FAIL stream_drain occ=%0d want 0", a_occ);
    end
  endtask

  task automatic test_flush();
    a_drive(1'b1, 32'h1, 1'b0);
    tick();
    a_drive(1'b1, 32'h2, 1'b0);
    tick();
    a_flush = 1'b1;
    a_drive(1'b1, 32'hD, 1'b0);
    tick();
    checks++;
    if (a_occ !== 2'd0 || a_out_valid !== 1'b0 || a_out_ctrl !== 8'h0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_state occ=%0d ov=%b ctrl=%0h ir=%b want 0/0/0/1",
               a_occ, a_out_valid, a_out_ctrl, a_in_ready);
    end
    checks++;
    if (a_drop !== 8'd2) begin
      errors++;
      $display("FAIL flush_drop drop=%0d want 2", a_drop);
    end
    a_drive(1'b0, 32'h0, 1'b1);
    tick();
    checks++;
    if (a_drop !== 8'd2) begin
      errors++;
      $display("FAIL flush_empty_drop drop=%0d want 2", a_drop);
    end
    a_flush = 1'b0;
    tick();
    checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== 32'h0) begin
      errors++;
      $display("FAIL flush_no_ghost ov=%b data=%0h want 0/0", a_out_valid, a_out_data);
    end
  endtask

  task automatic test_clr_full();
    a_drive(1'b1, 32'h5, 1'b0);
    tick();
    a_drive(1'b1, 32'h6, 1'b0);
    tick();
    a_clr = 1'b1;
    a_drive(1'b1, 32'h7, 1'b1);
    tick();
    checks++;
    if (a_occ !== 2'd0 || a_out_valid !== 1'b0 || a_drop !== 8'd0) begin
      errors++;
      $display("FAIL clr_full occ=%0d ov=%b drop=%0d want 0/0/0", a_occ, a_out_valid, a_drop);
    end
    a_clr = 1'b0;
    a_drive(1'b0, 32'h0, 1'b1);
    tick();
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_no_pop ov=%b want 0", a_out_valid);
    end
  endtask

  task automatic test_clr_flush();
    a_drive(1'b1, 32'h8, 1'b0);
    tick();
    a_flush = 1'b1;
    a_drive(1'b0, 32'h0, 1'b0);
    tick();
    a_flush = 1'b0;
    a_drive(1'b1, 32'h9, 1'b0);
    tick();
    checks++;
    if (a_drop !== 8'd1 || a_occ !== 2'd1) begin
      errors++;
      $display("FAIL clrflush_setup drop=%0d occ=%0d want 1/1", a_drop, a_occ);
    end
    a_clr   = 1'b1;
    a_flush = 1'b1;
    a_drive(1'b0, 32'h0, 1'b0);
    tick();
    checks++;
    if (a_drop !== 8'd0 || a_occ !== 2'd0) begin
      errors++;
      $display("FAIL clr_over_flush drop=%0d occ=%0d want 0/0", a_drop, a_occ);
    end
    a_clr   = 1'b0;
    a_flush = 1'b0;
  endtask

  task automatic b_fill(input int n);
    for (int i = 0; i < n; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = 8'(i + 1);
      tick();
    end
    b_in_valid = 1'b0;
  endtask

  task automatic test_drop_saturate();
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    b_fill(2);
    b_flush = 1'b1;
    tick();
    b_flush = 1'b0;
    checks++;
    if (b_drop !== 2'd2) begin
      errors++;
      $display("FAIL sat_preset drop=%0d want 2", b_drop);
    end
    b_fill(2);
    b_flush = 1'b1;
    tick();
    b_flush = 1'b0;
    checks++;
    if (b_drop !== 2'd3 || b_occ !== 2'd0) begin
      errors++;
      $display("FAIL sat_full drop=%0d occ=%0d want 3/0", b_drop, b_occ);
    end
    b_fill(1);
    b_flush = 1'b1;
    tick();
    b_flush = 1'b0;
    checks++;
    if (b_drop !== 2'd3) begin
      errors++;
      $display("FAIL sat_hold drop=%0d want 3", b_drop);
    end
  endtask

  initial begin
    a_clr = 1'b0;
    a_flush = 1'b0;
    a_drive(1'b0, 32'h0, 1'b0);
    b_clr = 1'b0;
    b_flush = 1'b0;
    b_in_valid = 1'b0;
    b_in_data = 8'h0;
    b_in_ctrl = 4'h3;
    b_out_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_stream();
    test_flush();
    test_clr_full();
    test_clr_flush();
    test_drop_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, meaning data payload width in bits.
REQ-002 SHALL provide parameter CTRL_W, default 8, meaning control-bit payload width in bits.
REQ-003 SHALL provide parameter CNT_W, default 8, meaning width of the drop counter.
REQ-004 SHALL provide port Clk  input  1  clock; all state updates on falling edge.
REQ-005 SHALL provide port Clr  input  1  synchronous reset, active-high.
REQ-006 SHALL provide port Flush  input  1  control-hazard flush, discards all held entries.
REQ-007 SHALL provide port In_Valid  input  1  upstream stage offers an entry.
REQ-008 SHALL provide port In_Ready  output  1  block can accept an entry this cycle.
REQ-009 SHALL provide port In_Data  input  WIDTH  upstream data payload.
REQ-010 SHALL provide port In_Ctrl  input  CTRL_W  upstream control payload.
REQ-011 SHALL provide port Out_Valid  output  1  head entry is valid.
REQ-012 SHALL provide port Out_Ready  input  1  downstream stage takes the head entry.
REQ-013 SHALL provide port Out_Data  output  WIDTH  head data payload.
REQ-014 SHALL provide port Out_Ctrl  output  CTRL_W  head control payload.
REQ-015 SHALL provide port Occupancy  output  2  number of held entries, 0..2.
REQ-016 SHALL provide port Drop_Cnt  output  CNT_W  count of valid entries discarded by Flush.

Function
REQ-017 SHALL hold at most two entries: a main register driving Out_* and a skid register.
REQ-018 SHALL implement states EMPTY (Occupancy=0), ONE (Occupancy=1) and FULL (Occupancy=2).
REQ-019 SHALL define accept as In_Valid && In_Ready and pop as Out_Valid && Out_Ready, both sampled at the falling edge.
REQ-020 SHALL drive In_Ready = (state != FULL) from registered state only, with no combinational path from Out_Ready.
REQ-021 SHALL drive Out_Valid = (state != EMPTY).
REQ-022 SHALL, in EMPTY, on accept load main and go to ONE.
REQ-023 SHALL, in ONE: on accept without pop, load skid and go to FULL; on pop without accept, go to EMPTY; on accept with pop, load main with the new entry and stay in ONE.
REQ-024 SHALL, in FULL, on pop move skid into main and go to ONE; no accept is possible while In_Ready=0.
REQ-025 SHALL preserve strict FIFO order, with no entry duplicated or lost except by Flush or Clr.
REQ-026 SHALL give a latency of one falling edge from accept into EMPTY to Out_Valid=1 with that entry.
REQ-027 SHALL force Out_Data=0 and Out_Ctrl=0 whenever the state is EMPTY, so that a bubble carries no side-effecting control.
REQ-028 SHALL, on Flush=1, go to EMPTY and clear main and skid to 0, with priority over accept and pop.
REQ-029 SHALL discard any entry accepted on a Flush edge.
REQ-030 SHALL, on Flush=1, add Occupancy (the pre-flush value) to Drop_Cnt, saturating at all-ones.
REQ-031 SHALL ensure that Flush while EMPTY leaves Drop_Cnt unchanged.
REQ-032 SHALL make In_Ready=1 on the edge after a Flush.
REQ-033 SHALL give Clr priority over Flush; Drop_Cnt is not incremented on a Clr edge.

Reset
REQ-034 SHALL, on Clr=1 at a falling edge, clear state to EMPTY and set Out_Valid=0, Out_Data=0, Out_Ctrl=0, Occupancy=0, Drop_Cnt=0 and In_Ready=1.
REQ-035 SHALL, when Clr asserts mid-operation in FULL, lose both entries with no pop reported.
REQ-036 SHALL ignore In_Valid on the Clr edge; accept is first possible on the edge after Clr deasserts.

Verification
REQ-037 SHALL cover: Clr then In_Valid=1, In_Data=0x11, Out_Ready=1 for one edge -> Out_Valid=1 and Out_Data=0x11 after one edge, then Out_Valid=0.
REQ-038 SHALL cover: Out_Ready=0 with entries 0xA, 0xB, 0xC offered on consecutive edges -> Occupancy 1 then 2, In_Ready=0, 0xC held off upstream; releasing Out_Ready -> outputs 0xA, 0xB, 0xC in order.
REQ-039 SHALL cover: streaming 0..9 with In_Valid=1 and Out_Ready=1 constantly -> Occupancy stays 1 and one entry is output per cycle.
REQ-040 SHALL cover: FULL with Flush=1 and In_Valid=1 (0xD) on the same edge -> EMPTY, Out_Ctrl=0, 0xD never appears, Drop_Cnt +2.
REQ-041 SHALL cover: Drop_Cnt preset near all-ones (CNT_W=2) then Flush from FULL -> Drop_Cnt=3 (saturated), and a further Flush -> Drop_Cnt remains 3.
REQ-042 SHALL cover: Clr and Flush asserted together while in ONE -> EMPTY with Drop_Cnt=0.
